secure_xform_unit: RTL and testbench
====================================

# secure_xform_unit

Parametrised, sequential successor to the combinational memory security transform. It sits between the register file and data memory. On the store path (enc channel) it scrambles register data bound for protected addresses. On the load path (dec channel) it descrambles memory data bound for registers. Both channels are gated by an access key, and repeated bad keys lock the unit out for a fixed period. Each channel uses a valid/ready handshake, and decryption uses a multi-cycle divider.

## Interface
- DATA_W, 32, data width of both channels
- ADDR_W, 10, address width
- KEY_W, 16, key width
- ACCESS_KEY, 16'h0032, the only key that grants access
- SECURE_BASE, 128, addresses strictly greater than this are transformed; others pass through
- OFFSET, 142, additive constant (15 + 127)
- MULT, 3, multiplicative constant; must be ≥ 2
- MAX_FAIL, 3, bad-key count that triggers lockout (≥ 1)
- LOCK_CYCLES, 64, lockout duration in clock cycles (≥ 1)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- enc_valid  in  1  store request
- enc_ready  out  1  enc channel can accept a request
- enc_data  in  DATA_W  register data to be stored
- enc_addr  in  ADDR_W  store address
- enc_key  in  KEY_W  store access key
- enc_out_valid  out  1  one-cycle result pulse
- enc_out_data  out  DATA_W  data to memory
- enc_out_err  out  1  request rejected
- dec_valid  in  1  load request
- dec_ready  out  1  dec channel can accept a request
- dec_data  in  DATA_W  data read from memory
- dec_addr  in  ADDR_W  load address
- dec_key  in  KEY_W  load access key
- dec_out_valid  out  1  one-cycle result pulse
- dec_out_data  out  DATA_W  data to register
- dec_out_err  out  1  request rejected
- locked  out  1  lockout active

## Operation
- **Accept rule.** A request is accepted on a cycle with valid && ready. Inputs are captured at acceptance. Outputs have no backpressure.
- **enc channel.** enc_ready is always 1 outside reset.
  - Good key, addr > SECURE_BASE: result is ((data + OFFSET) * MULT) mod 2^DATA_W.
  - Good key, addr ≤ SECURE_BASE: data passes through unchanged.
- **dec channel.** States are IDLE, DIV, DONE.
  - IDLE: dec_ready=1.
  - Good key, addr > SECURE_BASE: go to DIV. A restoring divider computes floor(data / MULT), one quotient bit per cycle, for DATA_W cycles. Then go to DONE.
  - DONE: output (quotient − OFFSET) mod 2^DATA_W, return to IDLE.
  - Good-key passthrough and all error responses go IDLE→DONE directly.
  - dec_ready=0 in DIV and DONE.
- **Bad key** (key ≠ ACCESS_KEY): the response has err=1 and data=0.
- **Failure counter fail_cnt.**
  - Counts bad-key acceptances; saturates at MAX_FAIL.
  - Two bad keys in the same cycle add 2.
  - A good-key acceptance clears it, unless the other channel presents a bad key in the same cycle. In that case the bad key wins and the count increments.
- **Lockout.**
  - Entered when fail_cnt reaches MAX_FAIL: locked=1 from the next cycle, and the lock timer is loaded with LOCK_CYCLES.
  - The timer decrements every cycle. When it reaches 0: locked=0 and fail_cnt=0.
  - While locked, every accepted request returns err=1, data=0 with latency 1, including good keys and requests already in the divider when lock begins. fail_cnt is frozen.
- **Arithmetic.** All arithmetic is unsigned modulo 2^DATA_W. The multiply and divide use DATA_W+2 internal bits where needed, so encryption of any data < (2^DATA_W)/MULT − OFFSET round-trips exactly.

## Timing
- **Reset values.** All outputs are 0, except enc_ready=1 and dec_ready=1 from the first cycle after rst deasserts. fail_cnt=0, lock timer=0, dec FSM in IDLE.
- **enc latency.** The result is valid 1 cycle after acceptance. Back-to-back requests give a result every cycle.
- **dec latency.** Secure transform: DATA_W+1 cycles after acceptance (33 at default). Passthrough and error: 1 cycle.
- locked rises 1 cycle after the accepting edge that saturates fail_cnt. It stays high for exactly LOCK_CYCLES cycles.
- rst asserted mid-division aborts the operation: no dec_out_valid, FSM returns to IDLE.
- Both channels may complete in the same cycle; they are independent apart from fail_cnt and locked.

## Test plan
- **Round trip.** enc data 0x10, addr 200, key 0x0032 → next cycle enc_out_data 0x1DA, err 0. Then dec data 0x1DA, addr 200 → 33 cycles later dec_out_data 0x10.
- **Boundary passthrough.** enc and dec with addr 128, data 0xDEADBEEF → both return 0xDEADBEEF after 1 cycle. Repeat with addr 129 → transformed.
- **Wrap.** enc data 0xFFFFFFFF, addr 300 → 0x1A7. dec data 0, addr 300 → 0xFFFFFF72. dec_ready stays 0 for the whole division.
- **Lockout.** Three enc requests with key 0x0031 → err=1 each, locked=1 one cycle after the third. A good-key enc during lock → err=1, data 0. Exactly 64 cycles later locked=0, and a good key succeeds.
- **Simultaneous events.** Bad key on enc with good key on dec in the same cycle → fail_cnt becomes 1 (not cleared). A bad key on both channels with fail_cnt=1 → lockout.
- **Reset mid-operation.** Assert rst 10 cycles into a secure dec → no dec_out_valid, dec_ready=1 the cycle after rst deasserts, all outputs 0.

Source files
------------

// File: rtl/secure_xform_unit.sv
// -----------------------------------------------------------------------------
// secure_xform_unit
//
// Keyed scramble/descramble stage between the register file and data memory.
//   enc channel (store path): ((data + OFFSET) * MULT) mod 2^DATA_W for
//     addresses above SECURE_BASE, passthrough otherwise. Result 1 cycle
//     after acceptance.
//   dec channel (load path):  floor(data / MULT) - OFFSET for addresses above
//     SECURE_BASE using a one-bit-per-cycle restoring divider (IDLE/DIV/DONE),
//     passthrough otherwise.
//   A wrong key gives err=1, data=0. Repeated wrong keys saturate a failure
//     counter and lock the unit out for LOCK_CYCLES cycles. While locked,
//     every accepted request and any division in flight is answered with
//     err=1, data=0 after one cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enc_valid/ready     store request handshake
//   enc_data/addr/key   store request payload
//   enc_out_valid/data/err  one-cycle store result
//   dec_valid/ready     load request handshake
//   dec_data/addr/key   load request payload
//   dec_out_valid/data/err  one-cycle load result
//   locked              lockout active
// -----------------------------------------------------------------------------
module secure_xform_unit #(
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 10,
    parameter int               KEY_W       = 16,
    parameter logic [KEY_W-1:0] ACCESS_KEY  = 16'h0032,
    parameter int               SECURE_BASE = 128,
    parameter int               OFFSET      = 142,
    parameter int               MULT        = 3,
    parameter int               MAX_FAIL    = 3,
    parameter int               LOCK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W-1:0] enc_data,
    input  logic [ADDR_W-1:0] enc_addr,
    input  logic [KEY_W-1:0]  enc_key,
    output logic              enc_out_valid,
    output logic [DATA_W-1:0] enc_out_data,
    output logic              enc_out_err,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [DATA_W-1:0] dec_data,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [KEY_W-1:0]  dec_key,
    output logic              dec_out_valid,
    output logic [DATA_W-1:0] dec_out_data,
    output logic              dec_out_err,
    output logic              locked
);

    localparam int EXT_W  = DATA_W + 2;
    localparam int SH_W   = EXT_W + 1;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    // Wide enough to hold MAX_FAIL + 2 before saturation.
    localparam int FAIL_W = $clog2(MAX_FAIL + 3);
    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [DATA_W-1:0] OFFSET_D   = DATA_W'(OFFSET);
    localparam logic [EXT_W-1:0]  OFFSET_X   = EXT_W'(OFFSET);
    localparam logic [EXT_W-1:0]  MULT_X     = EXT_W'(MULT);
    localparam logic [SH_W-1:0]   MULT_S     = SH_W'(MULT);
    localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(SECURE_BASE);
    localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  LOCK_LOAD  = TMR_W'(LOCK_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Store-path scramble; the sum and product are formed at DATA_W+2 bits.
    function automatic logic [DATA_W-1:0] enc_xform(input logic [DATA_W-1:0] d);
        return DATA_W'(({2'b00, d} + OFFSET_X) * MULT_X);
    endfunction

    logic              enc_acc_s;
    logic              enc_key_ok_s;
    logic              enc_secure_s;
    logic              enc_bad_s;
    logic              enc_good_s;
    logic              dec_acc_s;
    logic              dec_key_ok_s;
    logic              dec_secure_s;
    logic              dec_bad_s;
    logic              dec_good_s;
    logic [FAIL_W-1:0] fail_sum_s;
    logic [FAIL_W-1:0] fail_next_s;
    logic [FAIL_W-1:0] fail_cnt_r;
    logic [TMR_W-1:0]  lock_timer_r;
    logic [1:0]        dec_state_r;
    logic [EXT_W-1:0]  div_rem_r;
    logic [DATA_W-1:0] div_dvd_r;
    logic [CNT_W-1:0]  div_cnt_r;
    logic [SH_W-1:0]   div_shift_s;
    logic [EXT_W-1:0]  div_rem_next_s;
    logic              div_bit_s;
    logic [DATA_W-1:0] div_dvd_next_s;

    // Request qualification for both channels.
    always_comb begin
        enc_acc_s    = enc_valid & enc_ready;
        enc_key_ok_s = (enc_key == ACCESS_KEY);
        enc_secure_s = (enc_addr > BASE_A);
        enc_bad_s    = enc_acc_s & ~enc_key_ok_s;
        enc_good_s   = enc_acc_s & enc_key_ok_s;
        dec_acc_s    = dec_valid & dec_ready;
        dec_key_ok_s = (dec_key == ACCESS_KEY);
        dec_secure_s = (dec_addr > BASE_A);
        dec_bad_s    = dec_acc_s & ~dec_key_ok_s;
        dec_good_s   = dec_acc_s & dec_key_ok_s;
    end

    // Next failure count: any bad key this cycle beats a good key on the other channel.
    always_comb begin
        fail_sum_s  = fail_cnt_r + FAIL_W'(enc_bad_s) + FAIL_W'(dec_bad_s);
        fail_next_s = fail_cnt_r;
        if (enc_bad_s || dec_bad_s) begin
            if (fail_sum_s >= MAX_FAIL_C) begin
                fail_next_s = MAX_FAIL_C;
            end else begin
                fail_next_s = fail_sum_s;
            end
        end else if (enc_good_s || dec_good_s) begin
            fail_next_s = {FAIL_W{1'b0}};
        end else begin
            fail_next_s = fail_cnt_r;
        end
    end

    // One restoring-division step; quotient bits shift into the dividend register.
    always_comb begin
        div_shift_s = {div_rem_r, div_dvd_r[DATA_W-1]};
        if (div_shift_s >= MULT_S) begin
            div_rem_next_s = EXT_W'(div_shift_s - MULT_S);
            div_bit_s      = 1'b1;
        end else begin
            div_rem_next_s = div_shift_s[EXT_W-1:0];
            div_bit_s      = 1'b0;
        end
        div_dvd_next_s = {div_dvd_r[DATA_W-2:0], div_bit_s};
    end

    // Failure counter, lockout flag and lockout timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_r   <= {FAIL_W{1'b0}};
            lock_timer_r <= {TMR_W{1'b0}};
            locked       <= 1'b0;
        end else if (locked) begin
            // Counter is frozen while locked; expiry clears it.
            if (lock_timer_r <= TMR_ONE) begin
                lock_timer_r <= {TMR_W{1'b0}};
                locked       <= 1'b0;
                fail_cnt_r   <= {FAIL_W{1'b0}};
            end else begin
                lock_timer_r <= lock_timer_r - TMR_ONE;
            end
        end else begin
            fail_cnt_r <= fail_next_s;
            if (fail_next_s >= MAX_FAIL_C) begin
                locked       <= 1'b1;
                lock_timer_r <= LOCK_LOAD;
            end else begin
                lock_timer_r <= lock_timer_r;
            end
        end
    end

    // Store channel: always ready, registered result one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_ready     <= 1'b0;
            enc_out_valid <= 1'b0;
            enc_out_data  <= {DATA_W{1'b0}};
            enc_out_err   <= 1'b0;
        end else begin
            enc_ready     <= 1'b1;
            enc_out_valid <= enc_acc_s;
            if (!enc_acc_s) begin
                enc_out_data <= {DATA_W{1'b0}};
                enc_out_err  <= 1'b0;
            end else if (locked || !enc_key_ok_s) begin
                enc_out_data <= {DATA_W{1'b0}};
                enc_out_err  <= 1'b1;
            end else if (enc_secure_s) begin
                enc_out_data <= enc_xform(enc_data);
                enc_out_err  <= 1'b0;
            end else begin
                enc_out_data <= enc_data;
                enc_out_err  <= 1'b0;
            end
        end
    end

    // Load channel FSM; dec_ready is registered as "next state is IDLE".
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_state_r   <= ST_IDLE;
            dec_ready     <= 1'b0;
            dec_out_valid <= 1'b0;
            dec_out_data  <= {DATA_W{1'b0}};
            dec_out_err   <= 1'b0;
            div_rem_r     <= {EXT_W{1'b0}};
            div_dvd_r     <= {DATA_W{1'b0}};
            div_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            dec_out_valid <= 1'b0;
            dec_out_data  <= {DATA_W{1'b0}};
            dec_out_err   <= 1'b0;
            case (dec_state_r)
                ST_IDLE: begin
                    if (!dec_acc_s) begin
                        dec_state_r <= ST_IDLE;
                        dec_ready   <= 1'b1;
                    end else if (locked || !dec_key_ok_s) begin
                        dec_state_r   <= ST_DONE;
                        dec_ready     <= 1'b0;
                        dec_out_valid <= 1'b1;
                        dec_out_err   <= 1'b1;
                    end else if (dec_secure_s) begin
                        dec_state_r <= ST_DIV;
                        dec_ready   <= 1'b0;
                        div_rem_r   <= {EXT_W{1'b0}};
                        div_dvd_r   <= dec_data;
                        div_cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        dec_state_r   <= ST_DONE;
                        dec_ready     <= 1'b0;
                        dec_out_valid <= 1'b1;
                        dec_out_data  <= dec_data;
                    end
                end
                ST_DIV: begin
                    dec_ready <= 1'b0;
                    if (locked) begin
                        // Lockout aborts an in-flight division with an error.
                        dec_state_r   <= ST_DONE;
                        dec_out_valid <= 1'b1;
                        dec_out_err   <= 1'b1;
                    end else begin
                        div_rem_r <= div_rem_next_s;
                        div_dvd_r <= div_dvd_next_s;
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                        if (div_cnt_r == CNT_LAST) begin
                            dec_state_r   <= ST_DONE;
                            dec_out_valid <= 1'b1;
                            dec_out_data  <= div_dvd_next_s - OFFSET_D;
                        end else begin
                            dec_state_r <= ST_DIV;
                        end
                    end
                end
                ST_DONE: begin
                    dec_state_r <= ST_IDLE;
                    dec_ready   <= 1'b1;
                end
                default: begin
                    dec_state_r <= ST_IDLE;
                    dec_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secure_xform_unit.sv
// -----------------------------------------------------------------------------
// tb_secure_xform_unit
//
// Directed bench for secure_xform_unit with hand-computed expected values:
// reset state, enc/dec round trip, address boundary, wrap-around, lockout
// timing, simultaneous bad/good keys, and reset during a division.
// -----------------------------------------------------------------------------
module tb_secure_xform_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid;
    logic        enc_ready;
    logic [31:0] enc_data;
    logic [9:0]  enc_addr;
    logic [15:0] enc_key;
    logic        enc_out_valid;
    logic [31:0] enc_out_data;
    logic        enc_out_err;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_data;
    logic [9:0]  dec_addr;
    logic [15:0] dec_key;
    logic        dec_out_valid;
    logic [31:0] dec_out_data;
    logic        dec_out_err;
    logic        locked;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] GOOD = 16'h0032;
    localparam logic [15:0] BAD  = 16'h0031;

    secure_xform_unit dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_data     (enc_data),
        .enc_addr     (enc_addr),
        .enc_key      (enc_key),
        .enc_out_valid(enc_out_valid),
        .enc_out_data (enc_out_data),
        .enc_out_err  (enc_out_err),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_addr     (dec_addr),
        .dec_key      (dec_key),
        .dec_out_valid(dec_out_valid),
        .dec_out_data (dec_out_data),
        .dec_out_err  (dec_out_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enc_req(input logic [31:0] d, input logic [9:0] a, input logic [15:0] k);
        enc_valid = 1'b1;
        enc_data  = d;
        enc_addr  = a;
        enc_key   = k;
        tick();
        enc_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as 1; also counts samples with dec_ready high.
    task automatic dec_req(input logic [31:0] d, input logic [9:0] a, input logic [15:0] k,
                           output int lat, output int rdy_hi);
        dec_valid = 1'b1;
        dec_data  = d;
        dec_addr  = a;
        dec_key   = k;
        tick();
        dec_valid = 1'b0;
        lat    = 1;
        rdy_hi = 0;
        while (!dec_out_valid && lat < 80) begin
            if (dec_ready) rdy_hi++;
            tick();
            lat++;
        end
        if (dec_ready) rdy_hi++;
    endtask

    initial begin
        int lat;
        int rdy_hi;
        int hi;
        int n;
        int vcount;

        rst = 1'b1;
        enc_valid = 1'b0; enc_data = 32'd0; enc_addr = 10'd0; enc_key = 16'd0;
        dec_valid = 1'b0; dec_data = 32'd0; dec_addr = 10'd0; dec_key = 16'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_enc_ready", 32'(enc_ready), 32'd1);
        check("reset_dec_ready", 32'(dec_ready), 32'd1);
        check("reset_outs", {enc_out_valid, enc_out_err, dec_out_valid, dec_out_err, locked}, 32'd0);
        check("reset_enc_data", enc_out_data, 32'd0);
        check("reset_dec_data", dec_out_data, 32'd0);

        // Round trip
        enc_req(32'h10, 10'd200, GOOD);
        check("rt_enc_valid", 32'(enc_out_valid), 32'd1);
        check("rt_enc_data", enc_out_data, 32'h1DA);
        check("rt_enc_err", 32'(enc_out_err), 32'd0);
        tick();
        check("rt_enc_pulse", 32'(enc_out_valid), 32'd0);
        dec_req(32'h1DA, 10'd200, GOOD, lat, rdy_hi);
        check("rt_dec_lat", 32'(lat), 32'd33);
        check("rt_dec_data", dec_out_data, 32'h10);
        check("rt_dec_err", 32'(dec_out_err), 32'd0);
        tick();
        check("rt_dec_ready_back", 32'(dec_ready), 32'd1);
        check("rt_dec_pulse", 32'(dec_out_valid), 32'd0);

        // Boundary: addr 128 passes through, 129 is transformed
        enc_req(32'hDEADBEEF, 10'd128, GOOD);
        check("b128_enc_data", enc_out_data, 32'hDEADBEEF);
        dec_req(32'hDEADBEEF, 10'd128, GOOD, lat, rdy_hi);
        check("b128_dec_lat", 32'(lat), 32'd1);
        check("b128_dec_data", dec_out_data, 32'hDEADBEEF);
        tick();
        enc_req(32'hDEADBEEF, 10'd129, GOOD);
        check("b129_enc_data", enc_out_data, 32'h9C093E77);
        dec_req(32'hDEADBEEF, 10'd129, GOOD, lat, rdy_hi);
        check("b129_dec_lat", 32'(lat), 32'd33);
        check("b129_dec_data", dec_out_data, 32'h4A39E9C1);
        tick();

        // Wrap-around
        enc_req(32'hFFFFFFFF, 10'd300, GOOD);
        check("wrap_enc_data", enc_out_data, 32'h1A7);
        dec_req(32'h0, 10'd300, GOOD, lat, rdy_hi);
        check("wrap_dec_lat", 32'(lat), 32'd33);
        check("wrap_dec_data", dec_out_data, 32'hFFFFFF72);
        check("wrap_dec_ready_low", 32'(rdy_hi), 32'd0);
        tick();

        // Lockout after three bad keys
        for (int i = 0; i < 3; i++) begin
            enc_req(32'h55, 10'd200, BAD);
            check("lock_bad_err", 32'(enc_out_err), 32'd1);
            check("lock_bad_data", enc_out_data, 32'd0);
            check("lock_flag", 32'(locked), (i == 2) ? 32'd1 : 32'd0);
        end
        hi = 1;
        enc_req(32'h10, 10'd200, GOOD);
        check("locked_good_err", 32'(enc_out_err), 32'd1);
        check("locked_good_data", enc_out_data, 32'd0);
        if (locked) hi++;
        n = 0;
        while (locked && n < 200) begin
            tick();
            n++;
            if (locked) hi++;
        end
        check("lock_duration", 32'(hi), 32'd64);
        check("lock_released", 32'(locked), 32'd0);
        enc_req(32'h10, 10'd200, GOOD);
        check("unlock_good_data", enc_out_data, 32'h1DA);
        check("unlock_good_err", 32'(enc_out_err), 32'd0);

        // Bad enc + good dec in one cycle: count goes to 1, not cleared
        enc_valid = 1'b1; enc_data = 32'h77; enc_addr = 10'd200; enc_key = BAD;
        dec_valid = 1'b1; dec_data = 32'h1234; dec_addr = 10'd50; dec_key = GOOD;
        tick();
        enc_valid = 1'b0; dec_valid = 1'b0;
        check("sim_enc_err", 32'(enc_out_err), 32'd1);
        check("sim_dec_valid", 32'(dec_out_valid), 32'd1);
        check("sim_dec_data", dec_out_data, 32'h1234);
        check("sim_dec_err", 32'(dec_out_err), 32'd0);
        tick();
        check("sim_not_locked", 32'(locked), 32'd0);
        // Two bad keys on top of a count of 1 reach the limit
        enc_valid = 1'b1; enc_data = 32'h1; enc_addr = 10'd200; enc_key = BAD;
        dec_valid = 1'b1; dec_data = 32'h2; dec_addr = 10'd200; dec_key = BAD;
        tick();
        enc_valid = 1'b0; dec_valid = 1'b0;
        check("dual_bad_dec_err", 32'(dec_out_err), 32'd1);
        check("dual_bad_dec_data", dec_out_data, 32'd0);
        check("dual_bad_locked", 32'(locked), 32'd1);
        hi = 1;
        n = 0;
        while (locked && n < 200) begin
            tick();
            n++;
            if (locked) hi++;
        end
        check("dual_lock_duration", 32'(hi), 32'd64);

        // Reset in the middle of a division
        dec_valid = 1'b1; dec_data = 32'h1DA; dec_addr = 10'd200; dec_key = GOOD;
        tick();
        dec_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_dec_ready", 32'(dec_ready), 32'd1);
        check("rstmid_enc_ready", 32'(enc_ready), 32'd1);
        check("rstmid_outs", {enc_out_valid, enc_out_err, dec_out_valid, dec_out_err, locked}, 32'd0);
        check("rstmid_dec_data", dec_out_data, 32'd0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dec_out_valid) vcount++;
        end
        check("rstmid_no_valid", 32'(vcount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
